ack_responder: RTL and testbench
================================

ACK_RESPONDER -- requirements
Module: ack_responder

Interface
REQ-001 The block SHALL have parameter ackDelay, default 3, giving the wait in cycles between packet acceptance and its acknowledgment; legal range 1..255.
REQ-002 The block SHALL have parameter dropEvery, default 4, giving the ack-suppression period; used only with ACK_DROP_EN; legal range 2..255.
REQ-003 The block SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port pktIn  input  1  packet-arrival strobe, one cycle per packet.
REQ-006 The block SHALL have port pktSeq  input  8  sequence number of the arriving packet, valid when pktIn=1.
REQ-007 The block SHALL have port ackOut  output  1  acknowledgment pulse, one cycle wide.
REQ-008 The block SHALL have port ackSeq  output  8  sequence number being acknowledged, valid when ackOut=1.
REQ-009 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 The block SHALL have ports rxCnt, dupCnt, dropCnt, ackDropCnt  output  32 each  counters: new packets, duplicates, packets ignored, acks suppressed.

Function
REQ-011 The block SHALL implement states IDLE, PROC and SEND, plus internal expSeq (8 bit, next expected sequence number) and delayCnt (8 bit).
REQ-012 In IDLE with pktIn=1 and pktSeq==expSeq, the block SHALL: increment rxCnt and expSeq (mod 256); latch ackSeq=pktSeq; load delayCnt=ackDelay-1; enter PROC.
REQ-013 In IDLE with pktIn=1, rxCnt!=0 and pktSeq==expSeq-1 (mod 256), the block SHALL:
- increment dupCnt;
- latch ackSeq=pktSeq;
- leave expSeq unchanged;
- load delayCnt=ackDelay-1 and enter PROC, so the lost ack is re-sent.
REQ-014 In IDLE with pktIn=1 and any other pktSeq, including a duplicate-looking value while rxCnt==0, the block SHALL increment dropCnt, stay in IDLE and emit no ack.
REQ-015 In PROC the block SHALL decrement delayCnt each cycle and enter SEND in the cycle after delayCnt reaches 0.
REQ-016 In SEND the block SHALL drive ackOut=1 for exactly that cycle and return to IDLE on the next edge.
REQ-017 The first ackOut cycle SHALL occur ackDelay+1 cycles after the edge that sampled the accepted pktIn.
REQ-018 pktIn=1 while in PROC or SEND SHALL increment dropCnt and leave all other state unchanged; it SHALL NOT be queued.
REQ-019 ackSeq SHALL hold its last latched value between acks.
REQ-020 All 32-bit counters SHALL wrap from 0xFFFFFFFF to 0 without saturation.
REQ-021 expSeq SHALL wrap from 255 to 0; the duplicate check of REQ-013 SHALL use the same mod-256 arithmetic, so pktSeq=255 is a duplicate when expSeq=0.

Reset
REQ-022 On rst=1 at a clock edge the block SHALL enter IDLE and clear ackOut, ackSeq, busy, expSeq, delayCnt and all four counters to 0.
REQ-023 Reset SHALL take priority over every other event, including mid-PROC and during SEND; a pending ack SHALL be discarded, not emitted.

Configuration
REQ-024 With macro ACK_RESPONDER_DROP_EN defined, the block SHALL count completed SEND cycles, and every dropEvery-th SEND (the 4th, 8th, ... for the default) SHALL keep ackOut=0 and increment ackDropCnt; all other timing SHALL be unchanged.
REQ-025 Without ACK_RESPONDER_DROP_EN, every SEND SHALL assert ackOut and ackDropCnt SHALL read constant 0.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Reset, then pktIn with pktSeq=0 at cycle 10 -> ackOut=1 and ackSeq=0 at cycle 14 only; rxCnt=1; expSeq=1.
- Accept seq 0, then after its ack send pktSeq=0 again -> dupCnt=1, re-ack of seq 0 four cycles later, rxCnt stays 1.
- Accept seq 0, then pktIn with seq 1 two cycles later during PROC -> dropCnt=1, single ack for seq 0.
- Send 256 in-order packets spaced 6 cycles apart -> expSeq wraps to 0, rxCnt=256; pktSeq=255 next -> treated as duplicate.
- Assert rst in the 2nd PROC cycle -> no ackOut follows; all outputs read 0 the cycle after reset.
- With ACK_RESPONDER_DROP_EN and dropEvery=4, send 8 in-order packets -> acks for seqs 3 and 7 suppressed, ackDropCnt=2, six ackOut pulses.

Source files
------------

// File: rtl/ack_responder.sv
// ack_responder
//   Acknowledges in-order packets after a fixed delay. A packet that repeats
//   the previous sequence number is a duplicate. Its ack is sent again,
//   because the first ack was probably lost. Any other packet is ignored and
//   counted as dropped. Packets that arrive while an ack is pending are also
//   dropped; they are never queued.
//
//   Optional feature (macro ACK_RESPONDER_DROP_EN): every dropEvery-th SEND
//   cycle keeps ackOut low and counts the suppressed ack in ackDropCnt. This
//   models a lossy ack channel. Without the macro, ackDropCnt is tied to 0.
//
// Parameters
//   ackDelay   cycles between packet acceptance and its ack (1..255)
//   dropEvery  ack-suppression period, used only with the macro (2..255)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   pktIn       one-cycle strobe per arriving packet
//   pktSeq      sequence number of the arriving packet
//   ackOut      one-cycle acknowledgment pulse
//   ackSeq      sequence number being acknowledged (holds between acks)
//   busy        high whenever the FSM is not IDLE
//   rxCnt       new in-order packets accepted
//   dupCnt      duplicates re-acknowledged
//   dropCnt     packets ignored
//   ackDropCnt  acks suppressed (macro builds only)
module ack_responder #(
  parameter int unsigned ackDelay  = 3,
  parameter int unsigned dropEvery = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pktIn,
  input  logic [7:0]  pktSeq,
  output logic        ackOut,
  output logic [7:0]  ackSeq,
  output logic        busy,
  output logic [31:0] rxCnt,
  output logic [31:0] dupCnt,
  output logic [31:0] dropCnt,
  output logic [31:0] ackDropCnt
);

  if (ackDelay < 1 || ackDelay > 255) begin : g_bad_delay
    $error("ack_responder: ackDelay out of range 1..255");
  end
  if (dropEvery < 2 || dropEvery > 255) begin : g_bad_drop
    $error("ack_responder: dropEvery out of range 2..255");
  end

  localparam logic [7:0] DELAY_LOAD = 8'(ackDelay - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROC = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t      state, stateNext;
  logic [7:0]  expSeq, expSeqNext;
  logic [7:0]  delayCnt, delayCntNext;
  logic [7:0]  ackSeqR, ackSeqNext;
  logic [31:0] rxCntR, rxCntNext;
  logic [31:0] dupCntR, dupCntNext;
  logic [31:0] dropCntR, dropCntNext;
  logic        isNew, isDup;
  logic        suppress;

  // Duplicate detection uses the same mod-256 arithmetic as expSeq.
  // That makes 255 a duplicate when expSeq has wrapped to 0. Before the
  // first accepted packet there is nothing to re-acknowledge.
  assign isNew = (pktSeq == expSeq);
  assign isDup = (rxCntR != '0) && (pktSeq == expSeq - 8'd1);

`ifdef ACK_RESPONDER_DROP_EN
  localparam logic [7:0] DROP_LAST = 8'(dropEvery - 1);

  logic [7:0]  sendCnt;
  logic [31:0] ackDropCntR;

  // sendCnt counts completed SENDs modulo dropEvery. Its last value marks
  // the SEND whose ack is swallowed.
  assign suppress = (sendCnt == DROP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sendCnt     <= '0;
      ackDropCntR <= '0;
    end else if (state == SEND) begin
      if (suppress) begin
        sendCnt     <= '0;
        ackDropCntR <= ackDropCntR + 32'd1;
      end else begin
        sendCnt <= sendCnt + 8'd1;
      end
    end
  end

  assign ackDropCnt = ackDropCntR;
`else
  assign suppress   = 1'b0;
  assign ackDropCnt = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      expSeq   <= '0;
      delayCnt <= '0;
      ackSeqR  <= '0;
      rxCntR   <= '0;
      dupCntR  <= '0;
      dropCntR <= '0;
    end else begin
      state    <= stateNext;
      expSeq   <= expSeqNext;
      delayCnt <= delayCntNext;
      ackSeqR  <= ackSeqNext;
      rxCntR   <= rxCntNext;
      dupCntR  <= dupCntNext;
      dropCntR <= dropCntNext;
    end
  end

  always_comb begin
    stateNext    = state;
    expSeqNext   = expSeq;
    delayCntNext = delayCnt;
    ackSeqNext   = ackSeqR;
    rxCntNext    = rxCntR;
    dupCntNext   = dupCntR;
    dropCntNext  = dropCntR;

    unique case (state)
      IDLE: begin
        if (pktIn) begin
          if (isNew) begin
            rxCntNext    = rxCntR + 32'd1;
            expSeqNext   = expSeq + 8'd1;
            ackSeqNext   = pktSeq;
            delayCntNext = DELAY_LOAD;
            stateNext    = PROC;
          end else if (isDup) begin
            dupCntNext   = dupCntR + 32'd1;
            ackSeqNext   = pktSeq;
            delayCntNext = DELAY_LOAD;
            stateNext    = PROC;
          end else begin
            dropCntNext = dropCntR + 32'd1;
          end
        end
      end
      PROC: begin
        if (pktIn) begin
          dropCntNext = dropCntR + 32'd1;
        end
        // The counter holds at 0 for one cycle before SEND. The ack
        // therefore lands ackDelay edges after the accepting edge.
        if (delayCnt == '0) begin
          stateNext = SEND;
        end else begin
          delayCntNext = delayCnt - 8'd1;
        end
      end
      SEND: begin
        if (pktIn) begin
          dropCntNext = dropCntR + 32'd1;
        end
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign ackOut  = (state == SEND) && !suppress;
  assign busy    = (state != IDLE);
  assign ackSeq  = ackSeqR;
  assign rxCnt   = rxCntR;
  assign dupCnt  = dupCntR;
  assign dropCnt = dropCntR;

endmodule

// File: tb/tb_ack_responder.sv
// Directed bench for ack_responder (ackDelay=3, dropEvery=4).
// Packets are driven on the falling edge, so the next rising edge samples
// them. An ack for a packet driven in cycle c appears in cycle c+4.
module tb_ack_responder;

`ifdef ACK_RESPONDER_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        pktIn;
  logic [7:0]  pktSeq;
  logic        ackOut;
  logic [7:0]  ackSeq;
  logic        busy;
  logic [31:0] rxCnt, dupCnt, dropCnt, ackDropCnt;

  ack_responder #(.ackDelay(3), .dropEvery(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .pktIn     (pktIn),
    .pktSeq    (pktSeq),
    .ackOut    (ackOut),
    .ackSeq    (ackSeq),
    .busy      (busy),
    .rxCnt     (rxCnt),
    .dupCnt    (dupCnt),
    .dropCnt   (dropCnt),
    .ackDropCnt(ackDropCnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ack monitor, sampled mid-cycle.
  int       ackCnt = 0;
  int       lastAckCyc = -1;
  int       seenCnt [256];
  logic [7:0] lastAckSeq = 8'h00;
  initial for (int i = 0; i < 256; i++) seenCnt[i] = 0;
  always @(negedge clk) begin
    if (ackOut === 1'b1) begin
      ackCnt     = ackCnt + 1;
      lastAckCyc = cyc;
      lastAckSeq = ackSeq;
      seenCnt[ackSeq] = seenCnt[ackSeq] + 1;
    end
  end

  int errors = 0;
  int checks = 0;
  int sentCyc;
  int base;
  int seen3, seen7;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] s);
    pktIn   = 1'b1;
    pktSeq  = s;
    sentCyc = cyc;
    @(negedge clk);
    pktIn   = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ackOut"},     {31'd0, ackOut}, 32'd0);
    chk({tag, "_ackSeq"},     {24'd0, ackSeq}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy},   32'd0);
    chk({tag, "_rxCnt"},      rxCnt,      32'd0);
    chk({tag, "_dupCnt"},     dupCnt,     32'd0);
    chk({tag, "_dropCnt"},    dropCnt,    32'd0);
    chk({tag, "_ackDropCnt"}, ackDropCnt, 32'd0);
  endtask

  initial begin
    rst    = 1'b1;
    pktIn  = 1'b0;
    pktSeq = 8'h00;
    idle(3);
    chk_all_zero("reset");
    rst = 1'b0;

    // First packet, seq 0, driven in cycle 10; the ack is expected in cycle 14 only.
    while (cyc < 10) @(negedge clk);
    base = ackCnt;
    send(8'd0);
    chk("s1_busy_proc", {31'd0, busy},   32'd1);
    chk("s1_no_early_ack", {31'd0, ackOut}, 32'd0);
    idle(6);
    chk("s1_ack_count", ackCnt - base,   1);
    chk("s1_ack_cycle", lastAckCyc,      14);
    chk("s1_ack_seq",   {24'd0, lastAckSeq}, 32'd0);
    chk("s1_rxCnt",     rxCnt,           32'd1);
    chk("s1_busy_idle", {31'd0, busy},   32'd0);

    // Seq 0 again is a duplicate and gets a re-ack.
    base = ackCnt;
    send(8'd0);
    idle(6);
    chk("s2_dupCnt",    dupCnt,          32'd1);
    chk("s2_rxCnt",     rxCnt,           32'd1);
    chk("s2_ack_count", ackCnt - base,   1);
    chk("s2_ack_cycle", lastAckCyc,      sentCyc + 4);
    chk("s2_ack_seq",   {24'd0, lastAckSeq}, 32'd0);

    // Seq 1 is accepted (expSeq was 1). Seq 2 arrives mid-PROC and is dropped.
    base = ackCnt;
    send(8'd1);
    sentCyc = sentCyc;
    base = base;
    idle(1);
    send(8'd2);
    idle(6);
    chk("s3_dropCnt",   dropCnt,         32'd1);
    chk("s3_ack_count", ackCnt - base,   1);
    chk("s3_ack_seq",   {24'd0, lastAckSeq}, 32'd1);
    chk("s3_ackSeq_hold", {24'd0, ackSeq}, 32'd1);
    chk("s3_rxCnt",     rxCnt,           32'd2);

    // Seq 2 is now in order. Reset in its second PROC cycle discards the ack.
    base = ackCnt;
    send(8'd2);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_all_zero("midreset");
    idle(6);
    chk("s5_no_ack",    ackCnt - base,   0);

    // After reset, 255 looks like a duplicate of expSeq-1 but rxCnt is 0.
    base = ackCnt;
    send(8'd255);
    idle(5);
    chk("s5_pre_dup_drop", dropCnt,      32'd1);
    chk("s5_pre_dup_nodup", dupCnt,      32'd0);
    chk("s5_pre_dup_noack", ackCnt - base, 0);

    // 256 in-order packets wrap expSeq back to 0.
    base = ackCnt;
    for (int i = 0; i < 256; i++) begin
      send(8'(i));
      idle(5);
    end
    chk("s4_rxCnt",     rxCnt,           32'd256);
    chk("s4_dupCnt",    dupCnt,          32'd0);
    chk("s4_dropCnt",   dropCnt,         32'd1);
    chk("s4_ack_count", ackCnt - base,   DROP ? 192 : 256);
    chk("s4_ackDropCnt", ackDropCnt,     DROP ? 32'd64 : 32'd0);
    chk("s4_ackSeq",    {24'd0, ackSeq}, 32'd255);

    // This is the 257th SEND since reset, so it is never suppressed.
    base = ackCnt;
    send(8'd255);
    idle(5);
    chk("s4_wrap_dup",      dupCnt,        32'd1);
    chk("s4_wrap_dup_rx",   rxCnt,         32'd256);
    chk("s4_wrap_dup_ack",  ackCnt - base, 1);
    chk("s4_wrap_dup_seq",  {24'd0, lastAckSeq}, 32'd255);
    chk("s4_wrap_dup_cyc",  lastAckCyc,    sentCyc + 4);

    send(8'd0);
    idle(5);
    chk("s4_wrap_new_rx",   rxCnt,         32'd257);
    chk("s4_wrap_new_seq",  {24'd0, lastAckSeq}, 32'd0);

    // Eight packets after reset. With the feature, acks 4 and 8 (seqs 3 and 7) are swallowed.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base  = ackCnt;
    seen3 = seenCnt[3];
    seen7 = seenCnt[7];
    for (int i = 0; i < 8; i++) begin
      send(8'(i));
      idle(5);
    end
    chk("s6_rxCnt",      rxCnt,                32'd8);
    chk("s6_ack_count",  ackCnt - base,        DROP ? 6 : 8);
    chk("s6_ackDropCnt", ackDropCnt,           DROP ? 32'd2 : 32'd0);
    chk("s6_seq3_acks",  seenCnt[3] - seen3,   DROP ? 0 : 1);
    chk("s6_seq7_acks",  seenCnt[7] - seen7,   DROP ? 0 : 1);
    chk("s6_ackSeq",     {24'd0, ackSeq},      32'd7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
